// File: rtl/rr_stream_mux_if.sv
// Stream bus for rr_stream_mux: N input channels with valid/ready/data,
// one registered output channel tagged with its source channel.
// With RR_STREAM_MUX_LOCK_EN defined, each input channel also carries in_last.
interface rr_stream_mux_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
);
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
`ifdef RR_STREAM_MUX_LOCK_EN
    logic [N-1:0]       in_last;
`endif
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_ready;

`ifdef RR_STREAM_MUX_LOCK_EN
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
`endif
endinterface

// File: rtl/rr_stream_mux.sv
// N-channel streaming mux with a single-entry registered output stage.
// mode=0: channel sel is passed through; mode=1: round-robin arbitration.
// Optional packet lock (round-robin holds a channel until in_last) is
// enabled by defining RR_STREAM_MUX_LOCK_EN.
module rr_stream_mux #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    rr_stream_mux_if.slave  bus
);

    logic             load;
    logic             grant_valid;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] grant_data;
    logic [N-1:0]     ready;
    logic [N-1:0]     onehot;
    int unsigned      idx;

    logic [SELW-1:0]  rr_ptr;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_chan_q;

`ifdef RR_STREAM_MUX_LOCK_EN
    logic             lock;
    logic [SELW-1:0]  lock_chan;
`endif

    // The stage accepts a new beat when empty or when its beat drains this cycle.
    assign load = !out_valid_q | bus.out_ready;

    // Arbitration: fixed select or round-robin search starting after rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        onehot      = '0;
        if (!mode) begin
            // sel values at or above N never match, so they yield no grant.
            for (int unsigned i = 0; i < N; i++) begin
                if (sel == SELW'(i) && bus.in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant       = SELW'(i);
                end
            end
        end else begin
            for (int unsigned k = 1; k <= N; k++) begin
                idx    = (32'(rr_ptr) + k) % N;
                onehot = N'(1) << idx;
`ifdef RR_STREAM_MUX_LOCK_EN
                if (!grant_valid && |(bus.in_valid & onehot) &&
                    (!lock || SELW'(idx) == lock_chan)) begin
`else
                if (!grant_valid && |(bus.in_valid & onehot)) begin
`endif
                    grant_valid = 1'b1;
                    grant       = SELW'(idx);
                end
            end
        end
    end

    // Steer ready to the granted channel and pick its data.
    always_comb begin
        ready      = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                ready[i]   = load & grant_valid;
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register, round-robin pointer and packet lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr      <= SELW'(N-1);
`ifdef RR_STREAM_MUX_LOCK_EN
            lock        <= 1'b0;
            lock_chan   <= '0;
`endif
        end else begin
            if (load) begin
                if (grant_valid) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= grant_data;
                    out_chan_q  <= grant;
                    if (mode) begin
                        rr_ptr <= grant;
`ifdef RR_STREAM_MUX_LOCK_EN
                        lock      <= !bus.in_last[grant];
                        lock_chan <= grant;
`endif
                    end
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
`ifdef RR_STREAM_MUX_LOCK_EN
            if (!mode) begin
                lock <= 1'b0;
            end
`endif
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: a 4-channel instance for the main
// checks and a 3-channel instance for the out-of-range select case.
// The packet-lock checks run only when RR_STREAM_MUX_LOCK_EN is defined.
module tb_rr_stream_mux;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [1:0] sel;
    logic       mode3;
    logic [1:0] sel3;

    int n_cmp = 0;
    int n_err = 0;

    rr_stream_mux_if #(.WIDTH(8), .N(4), .SELW(2)) bus ();
    rr_stream_mux_if #(.WIDTH(8), .N(3), .SELW(2)) bus3 ();

    rr_stream_mux #(.WIDTH(8), .N(4), .SELW(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .bus   (bus)
    );

    rr_stream_mux #(.WIDTH(8), .N(3), .SELW(2)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode3),
        .sel   (sel3),
        .bus   (bus3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        mode           = 1'b0;
        sel            = 2'd0;
        bus.in_valid   = '0;
        bus.in_data    = {8'h13, 8'hA5, 8'h11, 8'h10};
        bus.out_ready  = 1'b1;
        mode3          = 1'b0;
        sel3           = 2'd0;
        bus3.in_valid  = '0;
        bus3.in_data   = {8'h22, 8'h21, 8'h20};
        bus3.out_ready = 1'b1;
`ifdef RR_STREAM_MUX_LOCK_EN
        bus.in_last    = '0;
        bus3.in_last   = '0;
`endif

        // Reset state
        #12;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data",  32'(bus.out_data),  32'h00);
        check("rst_chan",  32'(bus.out_chan),  32'd0);
        rst_n = 1'b1;

        // Fixed select of channel 2
        mode = 1'b0;
        sel  = 2'd2;
        bus.in_valid = 4'b1111;
        #1;
        check("fix_ready0", 32'(bus.in_ready), 32'b0100);
        for (int i = 0; i < 3; i++) begin
            step();
            check("fix_valid", 32'(bus.out_valid), 32'd1);
            check("fix_data",  32'(bus.out_data),  32'hA5);
            check("fix_chan",  32'(bus.out_chan),  32'd2);
            check("fix_ready", 32'(bus.in_ready),  32'b0100);
        end

        // Round-robin, all valid: pointer still at 3 after mode-0 traffic
        mode = 1'b1;
        bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_all_chan", 32'(bus.out_chan), 32'(k % 4));
            check("rr_all_data", 32'(bus.out_data), 32'(8'h10 + k % 4));
        end

        // Round-robin, channels 1 and 3 only
        bus.in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_13_chan", 32'(bus.out_chan), (k % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Backpressure: load a ch0 beat, then stall for 3 cycles
        bus.in_valid = 4'b1111;
        step();
        check("bp_load_chan", 32'(bus.out_chan), 32'd0);
        check("bp_load_data", 32'(bus.out_data), 32'h10);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.in_data  = {8'(8'h23 + c), 8'(8'h22 + c), 8'(8'h21 + c), 8'(8'h20 + c)};
            bus.in_valid = (c == 1) ? 4'b0101 : 4'b1111;
            #1;
            check("bp_ready", 32'(bus.in_ready), 32'd0);
            step();
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_chan",  32'(bus.out_chan),  32'd0);
            check("bp_data",  32'(bus.out_data),  32'h10);
        end
        // Release: drain and refill in the same cycle
        bus.in_data   = {8'h33, 8'h32, 8'h77, 8'h30};
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        #1;
        check("bp_rel_ready", 32'(bus.in_ready), 32'b0010);
        step();
        check("bp_rel_valid", 32'(bus.out_valid), 32'd1);
        check("bp_rel_chan",  32'(bus.out_chan),  32'd1);
        check("bp_rel_data",  32'(bus.out_data),  32'h77);

        // Asynchronous reset mid-stream, between clock edges
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_data",  32'(bus.out_data),  32'h00);
        check("mrst_chan",  32'(bus.out_chan),  32'd0);
        rst_n = 1'b1;
        bus.in_valid = 4'b0100;

        // Single beat then drain to empty
        step();
        check("drn_valid1", 32'(bus.out_valid), 32'd1);
        check("drn_chan",   32'(bus.out_chan),  32'd2);
        check("drn_data",   32'(bus.out_data),  32'h32);
        bus.in_valid = 4'b0000;
        #1;
        check("drn_ready", 32'(bus.in_ready), 32'd0);
        step();
        check("drn_valid0", 32'(bus.out_valid), 32'd0);

        // N=3: sel in range, then sel=3 out of range
        mode3 = 1'b0;
        sel3  = 2'd1;
        bus3.in_valid = 3'b111;
        step();
        check("n3_valid1", 32'(bus3.out_valid), 32'd1);
        check("n3_chan",   32'(bus3.out_chan),  32'd1);
        check("n3_data",   32'(bus3.out_data),  32'h21);
        sel3 = 2'd3;
        #1;
        check("n3_oor_ready", 32'(bus3.in_ready), 32'd0);
        step();
        check("n3_oor_valid", 32'(bus3.out_valid), 32'd0);

`ifdef RR_STREAM_MUX_LOCK_EN
        // Packet lock: ch0 sends 3 beats while ch1 stays valid
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        mode = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b0011;
        bus.in_data   = {8'h00, 8'h00, 8'h50, 8'h40};
        for (int b = 0; b < 3; b++) begin
            bus.in_last     = (b == 2) ? 4'b0001 : 4'b0000;
            bus.in_data[7:0] = 8'(8'h40 + b);
            #1;
            check("lk_ready", 32'(bus.in_ready), 32'b0001);
            step();
            check("lk_chan", 32'(bus.out_chan), 32'd0);
            check("lk_data", 32'(bus.out_data), 32'(8'h40 + b));
        end
        bus.in_last = 4'b0000;
        #1;
        check("lk_rel_ready", 32'(bus.in_ready), 32'b0010);
        step();
        check("lk_rel_chan", 32'(bus.out_chan), 32'd1);
        check("lk_rel_data", 32'(bus.out_data), 32'h50);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
